// File: rtl/car_collision_unit.sv
// car_collision_unit: player-side lane control and collision detection.
// Tracks the player's lane from two raw push-buttons, confirms overlap with
// the traffic car over CONFIRM_CYCLES consecutive cycles, drives a sticky
// collision level for traffic_controller and counts dodged traffic cars.
// Optional feature: define LANE_WRAP_EN to make lane moves wrap around the
// edge columns instead of saturating.
module car_collision_unit #(
   parameter int NUM_LANES      = 4,
   parameter int CAR_Y          = 400,
   parameter int CAR_H          = 40,
   parameter int TRAFFIC_H      = 40,
   parameter int CONFIRM_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       game_over,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       traffic_active,
   input  logic [1:0] active_column,
   input  logic [9:0] traffic_y_position,
   output logic [1:0] car_column,
   output logic       collision,
   output logic [7:0] dodge_count,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CONFIRM = 2'd2,
      ST_HIT     = 2'd3
   } state_t;

   localparam logic [1:0]  LANE_RESET  = 2'(NUM_LANES / 2);
   localparam logic [1:0]  LANE_MAX    = 2'(NUM_LANES - 1);
   localparam logic [10:0] CAR_Y_W     = 11'(CAR_Y);
   localparam logic [10:0] CAR_BOTTOM  = 11'(CAR_Y + CAR_H);
   localparam logic [10:0] TRAFFIC_H_W = 11'(TRAFFIC_H);
   localparam logic [3:0]  CONFIRM_W   = 4'(CONFIRM_CYCLES);

   // Button synchronizers and edge-detect history
   logic btn_l_s1_q, btn_l_s1_d, btn_l_s2_q, btn_l_s2_d, btn_l_prev_q, btn_l_prev_d;
   logic btn_r_s1_q, btn_r_s1_d, btn_r_s2_q, btn_r_s2_d, btn_r_prev_q, btn_r_prev_d;
   logic left_edge, right_edge;

   // Game state
   logic       traffic_prev_q, traffic_prev_d;
   logic       traffic_fall;
   logic [1:0] car_column_q, car_column_d;
   logic       collision_q, collision_d;
   logic [7:0] dodge_q, dodge_d;
   logic [3:0] cnt_q, cnt_d;
   state_t     state_q, state_d;
   logic       overlap;

   // Two-flop synchronizers, rising-edge detect on the synchronized level
   always_comb begin
      btn_l_s1_d   = btn_left;
      btn_l_s2_d   = btn_l_s1_q;
      btn_l_prev_d = btn_l_s2_q;
      btn_r_s1_d   = btn_right;
      btn_r_s2_d   = btn_r_s1_q;
      btn_r_prev_d = btn_r_s2_q;
      left_edge    = btn_l_s2_q & ~btn_l_prev_q;
      right_edge   = btn_r_s2_q & ~btn_r_prev_q;
      traffic_prev_d = traffic_active;
      traffic_fall   = traffic_prev_q & ~traffic_active;
   end

   // Overlap of the traffic car with the player car, 11-bit so no wrap
   always_comb begin
      overlap = traffic_active
             && (active_column == car_column_q)
             && (({1'b0, traffic_y_position} + TRAFFIC_H_W) > CAR_Y_W)
             && ({1'b0, traffic_y_position} < CAR_BOTTOM);
   end

   // Lane movement: a lone edge moves one column, frozen while stopped or hit
   always_comb begin
      car_column_d = car_column_q;
      if (start && !game_over && (state_q != ST_HIT)) begin
         if (left_edge && !right_edge) begin
            if (car_column_q == 2'd0) begin
`ifdef LANE_WRAP_EN
               car_column_d = LANE_MAX;
`else
               car_column_d = 2'd0;
`endif
            end else begin
               car_column_d = car_column_q - 2'd1;
            end
         end else if (right_edge && !left_edge) begin
            if (car_column_q >= LANE_MAX) begin
`ifdef LANE_WRAP_EN
               car_column_d = 2'd0;
`else
               car_column_d = LANE_MAX;
`endif
            end else begin
               car_column_d = car_column_q + 2'd1;
            end
         end
      end
   end

   // Hit-confirmation FSM, sticky collision and dodge counter
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      collision_d = collision_q;
      dodge_d     = dodge_q;
      if (!start) begin
         state_d     = ST_IDLE;
         cnt_d       = 4'd0;
         collision_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               collision_d = 1'b0;
               state_d     = ST_ARMED;
            end
            ST_ARMED: begin
               if (overlap) begin
                  cnt_d = 4'd1;
                  if (CONFIRM_CYCLES == 1) begin
                     state_d     = ST_HIT;
                     collision_d = 1'b1;
                  end else begin
                     state_d = ST_CONFIRM;
                  end
               end else if (traffic_fall && (dodge_q != 8'hFF)) begin
                  dodge_d = dodge_q + 8'd1;
               end
            end
            ST_CONFIRM: begin
               if (overlap) begin
                  cnt_d = cnt_q + 4'd1;
                  if ((cnt_q + 4'd1) >= CONFIRM_W) begin
                     state_d     = ST_HIT;
                     collision_d = 1'b1;
                  end
               end else begin
                  cnt_d   = 4'd0;
                  state_d = ST_ARMED;
               end
            end
            ST_HIT: begin
               collision_d = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // All state registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_l_s1_q     <= 1'b0;
         btn_l_s2_q     <= 1'b0;
         btn_l_prev_q   <= 1'b0;
         btn_r_s1_q     <= 1'b0;
         btn_r_s2_q     <= 1'b0;
         btn_r_prev_q   <= 1'b0;
         traffic_prev_q <= 1'b0;
         car_column_q   <= LANE_RESET;
         collision_q    <= 1'b0;
         dodge_q        <= 8'd0;
         cnt_q          <= 4'd0;
         state_q        <= ST_IDLE;
      end else begin
         btn_l_s1_q     <= btn_l_s1_d;
         btn_l_s2_q     <= btn_l_s2_d;
         btn_l_prev_q   <= btn_l_prev_d;
         btn_r_s1_q     <= btn_r_s1_d;
         btn_r_s2_q     <= btn_r_s2_d;
         btn_r_prev_q   <= btn_r_prev_d;
         traffic_prev_q <= traffic_prev_d;
         car_column_q   <= car_column_d;
         collision_q    <= collision_d;
         dodge_q        <= dodge_d;
         cnt_q          <= cnt_d;
         state_q        <= state_d;
      end
   end

   assign car_column  = car_column_q;
   assign collision   = collision_q;
   assign dodge_count = dodge_q;
   assign state_dbg   = state_q;

endmodule
